// File: rtl/dac_pkg.sv
// Shared DAC serial-frame definitions: frame layout, header field positions,
// the write command and the receiver state encoding (also used by the transmitter).
package dac_pkg;

  localparam int FRAME_BITS = 24;
  localparam int HDR_BITS   = 8;
  localparam int DATA_BITS  = 16;
  localparam int NUM_CH     = 4;
  localparam int CHAN_W     = 2;
  localparam int CNT_W      = 16;
  localparam int BCNT_W     = 5;

  localparam logic [3:0] CMD_WRITE = 4'h1;

  localparam int HDR_CMD_MSB  = 7;
  localparam int HDR_CMD_LSB  = 4;
  localparam int HDR_RSV_HI   = 3;
  localparam int HDR_CHAN_MSB = 2;
  localparam int HDR_CHAN_LSB = 1;
  localparam int HDR_RSV_LO   = 0;

  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CHECK   = 2'd2,
    WAIT_HI = 2'd3
  } rx_state_t;

  function automatic logic hdr_is_write(input logic [HDR_BITS-1:0] hdr);
    return (hdr[HDR_CMD_MSB:HDR_CMD_LSB] == CMD_WRITE) &&
           (hdr[HDR_RSV_HI] == 1'b0) && (hdr[HDR_RSV_LO] == 1'b0);
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/dac_shift_lane.sv
// One serial lane: 24-bit MSB-first shift register, advancing only when enabled.
module dac_shift_lane
  import dac_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_bit,
  output logic [FRAME_BITS-1:0] o_word
);

  logic [FRAME_BITS-1:0] r_word;

  // Shift register; holds its contents while the frame is being checked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= {FRAME_BITS{1'b0}};
    end else if (i_load) begin
      r_word <= {r_word[FRAME_BITS-2:0], i_bit};
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/dac_frame_rx.sv
// DAC frame receiver: deserialises sync/din frames, decodes the header and keeps
// per-channel values. Define DUAL_LANE_EN to add the parallel din_1 lane.
module dac_frame_rx
  import dac_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sync,
  input  logic                        din,
  input  logic                        din_1,
  output logic                        rx_valid,
  output logic [HDR_BITS-1:0]         rx_header,
  output logic [CHAN_W-1:0]           rx_chan,
  output logic [DATA_BITS-1:0]        rx_data,
  output logic [DATA_BITS-1:0]        rx_data_1,
  output logic [NUM_CH*DATA_BITS-1:0] ch_val,
  output logic                        frame_err,
  output logic                        cmd_err,
  output logic [CNT_W-1:0]            frame_cnt,
  output logic [CNT_W-1:0]            err_cnt
);

  rx_state_t r_state, w_state_nxt;
  logic [BCNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic w_shift_en, w_good, w_bad, w_frame_err, w_hdr_ok;

  logic [FRAME_BITS-1:0] w_word0;
  logic [HDR_BITS-1:0]   w_hdr;
  logic [DATA_BITS-1:0]  w_data;
  logic [CHAN_W-1:0]     w_chan;

  logic                        r_rx_valid, r_frame_err, r_cmd_err;
  logic [HDR_BITS-1:0]         r_rx_header;
  logic [CHAN_W-1:0]           r_rx_chan;
  logic [DATA_BITS-1:0]        r_rx_data;
  logic [NUM_CH*DATA_BITS-1:0] r_ch_val;
  logic [CNT_W-1:0]            r_frame_cnt, r_err_cnt;

  dac_shift_lane u_lane0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_shift_en),
    .i_bit  (din),
    .o_word (w_word0)
  );

  assign w_hdr  = w_word0[FRAME_BITS-1:DATA_BITS];
  assign w_data = w_word0[DATA_BITS-1:0];
  assign w_chan = w_hdr[HDR_CHAN_MSB:HDR_CHAN_LSB];

`ifdef DUAL_LANE_EN
  logic [FRAME_BITS-1:0] w_word1;
  logic [DATA_BITS-1:0]  r_rx_data_1;

  dac_shift_lane u_lane1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_shift_en),
    .i_bit  (din_1),
    .o_word (w_word1)
  );

  // Both lanes must carry the same header for the frame to be accepted.
  assign w_hdr_ok = hdr_is_write(w_hdr) && (w_word1[FRAME_BITS-1:DATA_BITS] == w_hdr);

  // Lane-1 data register, updated alongside rx_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data_1 <= {DATA_BITS{1'b0}};
    end else if (w_good) begin
      r_rx_data_1 <= w_word1[DATA_BITS-1:0];
    end
  end

  assign rx_data_1 = r_rx_data_1;
`else
  logic w_unused_din_1;

  assign w_unused_din_1 = din_1;
  assign w_hdr_ok       = hdr_is_write(w_hdr);
  assign rx_data_1      = {DATA_BITS{1'b0}};
`endif

  // State and bit-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= {BCNT_W{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  // Next-state decode; CHECK also absorbs the sync-high gap between frames.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_en    = 1'b0;
    w_good        = 1'b0;
    w_bad         = 1'b0;
    w_frame_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!sync) begin
          w_shift_en    = 1'b1;
          w_bit_cnt_nxt = {{(BCNT_W-1){1'b0}}, 1'b1};
          w_state_nxt   = SHIFT;
        end else begin
          w_bit_cnt_nxt = {BCNT_W{1'b0}};
          w_state_nxt   = IDLE;
        end
      end
      SHIFT: begin
        if (!sync) begin
          w_shift_en    = 1'b1;
          w_bit_cnt_nxt = r_bit_cnt + {{(BCNT_W-1){1'b0}}, 1'b1};
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = CHECK;
          end else begin
            w_state_nxt = SHIFT;
          end
        end else begin
          w_frame_err   = 1'b1;
          w_bit_cnt_nxt = {BCNT_W{1'b0}};
          w_state_nxt   = IDLE;
        end
      end
      CHECK: begin
        w_good        = w_hdr_ok;
        w_bad         = !w_hdr_ok;
        w_bit_cnt_nxt = {BCNT_W{1'b0}};
        if (sync) begin
          w_state_nxt = IDLE;
        end else begin
          w_frame_err = 1'b1;
          w_state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (sync) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT_HI;
        end
      end
      default: begin
        w_bit_cnt_nxt = {BCNT_W{1'b0}};
        w_state_nxt   = IDLE;
      end
    endcase
  end

  // Registered result outputs, pulses and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_valid  <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_header <= {HDR_BITS{1'b0}};
      r_rx_chan   <= {CHAN_W{1'b0}};
      r_rx_data   <= {DATA_BITS{1'b0}};
      r_ch_val    <= {(NUM_CH*DATA_BITS){1'b0}};
      r_frame_cnt <= {CNT_W{1'b0}};
      r_err_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_rx_valid  <= w_good;
      r_cmd_err   <= w_bad;
      r_frame_err <= w_frame_err;
      if (w_good) begin
        r_rx_header                           <= w_hdr;
        r_rx_chan                             <= w_chan;
        r_rx_data                             <= w_data;
        r_ch_val[w_chan*DATA_BITS +: DATA_BITS] <= w_data;
      end
      r_frame_cnt <= sat_add(r_frame_cnt, {1'b0, w_good});
      r_err_cnt   <= sat_add(r_err_cnt, {1'b0, w_bad} + {1'b0, w_frame_err});
    end
  end

  assign rx_valid  = r_rx_valid;
  assign cmd_err   = r_cmd_err;
  assign frame_err = r_frame_err;
  assign rx_header = r_rx_header;
  assign rx_chan   = r_rx_chan;
  assign rx_data   = r_rx_data;
  assign ch_val    = r_ch_val;
  assign frame_cnt = r_frame_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_dac_frame_rx.sv
// Bench for dac_frame_rx: directed frame table, random frame streams against a
// frame-level reference model, async reset mid-frame, dual-lane cases.
`timescale 1ns/1ps
module tb_dac_frame_rx;

`ifdef DUAL_LANE_EN
  localparam bit DUAL_EN = 1'b1;
`else
  localparam bit DUAL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, sync, din, din_1;
  logic        rx_valid, frame_err, cmd_err;
  logic [7:0]  rx_header;
  logic [1:0]  rx_chan;
  logic [15:0] rx_data, rx_data_1, frame_cnt, err_cnt;
  logic [63:0] ch_val;

  always #5 clk = ~clk;

  dac_frame_rx dut (
    .clk(clk), .rst_n(rst_n), .sync(sync), .din(din), .din_1(din_1),
    .rx_valid(rx_valid), .rx_header(rx_header), .rx_chan(rx_chan),
    .rx_data(rx_data), .rx_data_1(rx_data_1), .ch_val(ch_val),
    .frame_err(frame_err), .cmd_err(cmd_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed { logic s; logic d; logic d1; } cyc_t;
  cyc_t stim[$];

  typedef struct {
    logic [7:0]  hdr;
    logic [15:0] data;
    int          len;
    logic [2:0]  pulses;   // {rx_valid, cmd_err, frame_err} seen during the frame
    logic [15:0] exp_data;
    logic [63:0] exp_ch;
    logic [15:0] exp_fcnt;
    logic [15:0] exp_ecnt;
  } vec_t;
  vec_t tbl[12];

  logic [7:0]  m_hdr;
  logic [15:0] m_data, m_data1, m_fcnt, m_ecnt;
  logic [63:0] m_ch;
  logic        seen_valid, seen_cerr, seen_ferr;

  task automatic check_vec(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [191:0] dut_bus();
    return {51'b0, rx_valid, cmd_err, frame_err, rx_header, rx_chan, rx_data,
            rx_data_1, ch_val, frame_cnt, err_cnt};
  endfunction

  task automatic model_clear();
    m_hdr = 8'h00; m_data = 16'h0000; m_data1 = 16'h0000;
    m_fcnt = 16'h0000; m_ecnt = 16'h0000; m_ch = 64'h0;
  endtask

  function automatic logic [15:0] bsat(input logic [15:0] c, input int inc);
    int t;
    t = int'(c) + inc;
    return (t > 65535) ? 16'hFFFF : 16'(t);
  endfunction

  function automatic logic hdr_good(input logic [23:0] a, input logic [23:0] b);
    logic g;
    g = (a[23:20] == 4'h1) && (a[19] == 1'b0) && (a[16] == 1'b0);
    return g && (!DUAL_EN || (a[23:16] == b[23:16]));
  endfunction

  task automatic push_frame(input logic [7:0] hdr, input logic [15:0] data,
                            input logic [23:0] w1, input int len, input int gap);
    logic [23:0] w0;
    w0 = {hdr, data};
    for (int i = 0; i < len; i++)
      stim.push_back('{1'b0, (i < 24) ? w0[23-i] : 1'($urandom),
                             (i < 24) ? w1[23-i] : 1'($urandom)});
    for (int i = 0; i < gap; i++)
      stim.push_back('{1'b1, 1'($urandom), 1'($urandom)});
  endtask

  // Reference: every maximal sync-low run is one frame attempt. Short runs report
  // frame_err when sync rises; full runs are judged one cycle after bit 24, with
  // frame_err added when sync is still low then.
  task automatic play(input string tag);
    int n;
    int i;
    logic [2:0]  ev[];
    logic [23:0] ew0[];
    logic [23:0] ew1[];
    n = stim.size();
    ev = new[n]; ew0 = new[n]; ew1 = new[n];
    for (int k = 0; k < n; k++) begin ev[k] = 3'b000; ew0[k] = 24'h0; ew1[k] = 24'h0; end
    i = 0;
    while (i < n) begin
      if (stim[i].s) begin
        i++;
      end else begin
        int s, len, e;
        logic [23:0] a, b;
        s = i; a = 24'h0; b = 24'h0;
        while (i < n && !stim[i].s) begin
          if (i - s < 24) begin a = {a[22:0], stim[i].d}; b = {b[22:0], stim[i].d1}; end
          i++;
        end
        len = i - s;
        e = (len < 24) ? i : s + 24;
        if (e < n) begin
          if (len < 24) ev[e] = 3'b001;
          else begin
            ev[e] = {hdr_good(a, b), !hdr_good(a, b), len > 24};
            ew0[e] = a; ew1[e] = b;
          end
        end
      end
    end
    seen_valid = 1'b0; seen_cerr = 1'b0; seen_ferr = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sync = stim[k].s; din = stim[k].d; din_1 = stim[k].d1;
      @(posedge clk); #1;
      if (ev[k][2]) begin
        m_hdr = ew0[k][23:16];
        m_data = ew0[k][15:0];
        m_data1 = DUAL_EN ? ew1[k][15:0] : 16'h0000;
        m_ch[ew0[k][18:17]*16 +: 16] = ew0[k][15:0];
        m_fcnt = bsat(m_fcnt, 1);
      end
      m_ecnt = bsat(m_ecnt, int'(ev[k][1]) + int'(ev[k][0]));
      seen_valid |= rx_valid; seen_cerr |= cmd_err; seen_ferr |= frame_err;
      check_vec(tag, dut_bus(), {51'b0, ev[k], m_hdr, m_hdr[2:1], m_data, m_data1,
                                 m_ch, m_fcnt, m_ecnt});
    end
    stim.delete();
  endtask

  initial begin
    tbl[0]  = '{8'h10, 16'h8C8B, 24, 3'b100, 16'h8C8B, 64'h0000_0000_0000_8C8B, 16'd1, 16'd0};
    tbl[1]  = '{8'h10, 16'h8000, 24, 3'b100, 16'h8000, 64'h0000_0000_0000_8000, 16'd2, 16'd0};
    tbl[2]  = '{8'h12, 16'hB0FB, 24, 3'b100, 16'hB0FB, 64'h0000_0000_B0FB_8000, 16'd3, 16'd0};
    tbl[3]  = '{8'h14, 16'h8C8B, 24, 3'b100, 16'h8C8B, 64'h0000_8C8B_B0FB_8000, 16'd4, 16'd0};
    tbl[4]  = '{8'h16, 16'h0000, 24, 3'b100, 16'h0000, 64'h0000_8C8B_B0FB_8000, 16'd5, 16'd0};
    tbl[5]  = '{8'h12, 16'h5555, 12, 3'b001, 16'h0000, 64'h0000_8C8B_B0FB_8000, 16'd5, 16'd1};
    tbl[6]  = '{8'h12, 16'h1111, 24, 3'b100, 16'h1111, 64'h0000_8C8B_1111_8000, 16'd6, 16'd1};
    tbl[7]  = '{8'h30, 16'h1234, 24, 3'b010, 16'h1111, 64'h0000_8C8B_1111_8000, 16'd6, 16'd2};
    tbl[8]  = '{8'h30, 16'h1234, 27, 3'b011, 16'h1111, 64'h0000_8C8B_1111_8000, 16'd6, 16'd4};
    tbl[9]  = '{8'h16, 16'hABCD, 26, 3'b101, 16'hABCD, 64'hABCD_8C8B_1111_8000, 16'd7, 16'd5};
    tbl[10] = '{8'h18, 16'h9999, 24, 3'b010, 16'hABCD, 64'hABCD_8C8B_1111_8000, 16'd7, 16'd6};
    tbl[11] = '{8'h11, 16'h9999, 24, 3'b010, 16'hABCD, 64'hABCD_8C8B_1111_8000, 16'd7, 16'd7};

    rst_n = 1'b0; sync = 1'b1; din = 1'b0; din_1 = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check_vec("reset_state", dut_bus(), 192'b0);
    rst_n = 1'b1;

    for (int t = 0; t < 12; t++) begin
      push_frame(tbl[t].hdr, tbl[t].data, {tbl[t].hdr, ~tbl[t].data}, tbl[t].len, 1);
      play("directed_cycle");
      check_vec("tbl_pulses", 192'({seen_valid, seen_cerr, seen_ferr}), 192'(tbl[t].pulses));
      check_vec("tbl_state", 192'({rx_data, ch_val, frame_cnt, err_cnt}),
                192'({tbl[t].exp_data, tbl[t].exp_ch, tbl[t].exp_fcnt, tbl[t].exp_ecnt}));
    end

    if (DUAL_EN) begin
      push_frame(8'h12, 16'hFFFF, {8'h12, 16'h0000}, 24, 1);
      play("dual_cycle");
      check_vec("dual_data", 192'({rx_data, rx_data_1}), 192'({16'hFFFF, 16'h0000}));
      push_frame(8'h12, 16'h5A5A, {8'h14, 16'h5A5A}, 24, 1);
      play("dual_mm_cycle");
      check_vec("dual_mismatch", 192'({seen_valid, seen_cerr, seen_ferr}), 192'(3'b010));
    end

    for (int f = 0; f < 60; f++) begin
      logic [7:0]  h;
      logic [15:0] d;
      logic [23:0] w1;
      int len;
      h = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'h1, 1'b0, 2'($urandom), 1'b0};
      d = 16'($urandom);
      w1 = {h, 16'($urandom)};
      if ($urandom_range(0, 7) == 0) w1[23:16] = 8'($urandom);
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 24;
      push_frame(h, d, w1, len, int'($urandom_range(1, 3)));
    end
    play("random_cycle");

    for (int i = 0; i < 10; i++) begin
      @(negedge clk); sync = 1'b0; din = 1'($urandom); din_1 = 1'($urandom);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_vec("async_reset", dut_bus(), 192'b0);
    sync = 1'b1;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(8'h14, 16'hC0DE, {8'h14, 16'h0F0F}, 24, 2);
    play("post_reset_cycle");
    check_vec("post_reset", 192'({rx_chan, ch_val, frame_cnt, err_cnt}),
              192'({2'd2, 64'h0000_C0DE_0000_0000, 16'd1, 16'd0}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
